riscv_fetchctrl: RTL and testbench
==================================

RISCV_FETCHCTRL -- requirements
Module: riscv_fetchctrl

Interface
REQ-001 SHALL have parameter width, default 64, meaning PC/address width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 64'h0, meaning first fetch address after reset.
REQ-003 SHALL have i_riscv_fetchctrl_clk  input  1  sole clock, rising edge.
REQ-004 SHALL have i_riscv_fetchctrl_rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have i_riscv_fetchctrl_pc  input  width  current PC from the PC register.
REQ-006 SHALL have i_riscv_fetchctrl_is_c  input  1  instruction at current PC is compressed.
REQ-007 SHALL have i_riscv_fetchctrl_imem_ready  input  1  instruction memory accepts a new fetch address.
REQ-008 SHALL have i_riscv_fetchctrl_hazard_stall  input  1  pipeline hazard stall from hazard unit.
REQ-009 SHALL have i_riscv_fetchctrl_br_redirect / i_riscv_fetchctrl_br_target  input  1 / width  taken branch or jump resolved in execute.
REQ-010 SHALL have i_riscv_fetchctrl_trap_valid / i_riscv_fetchctrl_trap_vec  input  1 / width  trap or mret redirect from CSR unit.
REQ-011 SHALL have i_riscv_fetchctrl_wfi / i_riscv_fetchctrl_irq_pending  input  1 / 1  WFI retiring; any enabled interrupt pending.
REQ-012 SHALL have o_riscv_fetchctrl_nextpc  output  width  value loaded into PC register.
REQ-013 SHALL have o_riscv_fetchctrl_stallpc  output  1  hold PC register.
REQ-014 SHALL have o_riscv_fetchctrl_flush  output  1  flush IF/ID and ID/EX stages.
REQ-015 SHALL have o_riscv_fetchctrl_state  output  2  current FSM state, for debug.

Function
REQ-016 SHALL implement FSM states BOOT, RUN, HOLD, SLEEP.
REQ-017 BOOT: nextpc=RESET_VEC, stallpc=0, flush=0; unconditional transition to RUN next cycle.
REQ-018 Redirect priority SHALL be trap > branch > WFI > sequential.
REQ-019 RUN, no redirect: nextpc = pc + 2 if is_c, else pc + 4; stallpc = hazard_stall OR NOT imem_ready; flush=0.
REQ-020 RUN, redirect with imem_ready=1: nextpc=selected target, stallpc=0, flush=1 for exactly that cycle; remain in RUN.
REQ-021 RUN, redirect with imem_ready=0: latch target into internal register, stallpc=1, flush=1 for exactly that cycle; go to HOLD.
REQ-022 A redirect SHALL override hazard_stall.
REQ-023 HOLD: stallpc=1 and flush=0 while imem_ready=0; when imem_ready=1, nextpc=latched target, stallpc=0; return to RUN.
REQ-024 HOLD, trap_valid=1: overwrite latch with trap_vec and pulse flush; branch redirects in HOLD SHALL be ignored.
REQ-025 RUN, wfi=1 with no redirect: stallpc=1; go to SLEEP; WFI is ignored if irq_pending=1 in the same cycle.
REQ-026 SLEEP: stallpc=1 until irq_pending=1; then perform the sequential behaviour of REQ-019 and return to RUN.
REQ-027 SLEEP, trap_valid=1: handle per REQ-020/021 and leave SLEEP.
REQ-028 Targets SHALL have bit 0 forced to 0; sequential addition SHALL wrap modulo 2^width.
REQ-029 Outputs SHALL be combinational from state and inputs; only state and the latched target are registered.

Reset
REQ-030 rst=1 at a clock edge SHALL force state=BOOT and clear the latched target to 0, overriding all other inputs, including mid-HOLD or mid-SLEEP.
REQ-031 While in BOOT after reset, the outputs are nextpc=RESET_VEC, stallpc=0, flush=0, state=BOOT.

Structure
REQ-032 The FSM state enum and the state encodings SHALL be in the shared package riscv_pkg (BOOT=0, RUN=1, HOLD=2, SLEEP=3).
REQ-033 SHALL instantiate one sub-module, riscv_pc, as the PC register (sync-reset variant), driven by nextpc/stallpc; its o_pc SHALL feed i_riscv_fetchctrl_pc at the top level.

Verification
REQ-034 Reset, then imem_ready=1 with RESET_VEC=0x1000 -> cycle 1 nextpc=0x1000, then 0x1004, 0x1006 with is_c=0,1.
REQ-035 Same-cycle br_redirect to 0x2000 and trap_valid to 0x8000 -> nextpc=0x8000, flush pulses for 1 cycle.
REQ-036 Branch to 0x3001 with imem_ready=0 for 3 cycles -> state HOLD, stallpc=1, then nextpc=0x3000 when ready.
REQ-037 pc=0xFFFF_FFFF_FFFF_FFFC, is_c=0 -> nextpc=0x0 (wrap).
REQ-038 WFI then irq_pending after 5 cycles -> stallpc=1 for 5 cycles; then nextpc=pc+4; state returns to RUN.
REQ-039 rst asserted mid-HOLD -> next cycle state=BOOT, latched target cleared, nextpc=RESET_VEC.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared definitions for the fetch control slice.
//   fetch_state_e : fetch FSM state encoding (also visible on the debug state port).
package riscv_pkg;

  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    RUN   = 2'd1,
    HOLD  = 2'd2,
    SLEEP = 2'd3
  } fetch_state_e;

endpackage

// File: rtl/riscv_pc.sv
// riscv_pc: program counter register with synchronous active-high reset.
//   clk     : clock, rising edge
//   rst     : synchronous reset, loads RESET_VEC
//   nextpc  : value loaded when not stalled
//   stallpc : hold current value
//   o_pc    : registered PC
module riscv_pc #(
  parameter int                 width     = 64,
  parameter logic [width-1:0]   RESET_VEC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [width-1:0] nextpc,
  input  logic             stallpc,
  output logic [width-1:0] o_pc
);

  always_ff @(posedge clk) begin
    if (rst) begin
      o_pc <= RESET_VEC;
    end else if (!stallpc) begin
      o_pc <= nextpc;
    end
  end

endmodule

// File: rtl/riscv_fetchctrl.sv
// riscv_fetchctrl: next-PC selection and fetch sequencing FSM.
//   i_riscv_fetchctrl_clk / _rst       : clock, synchronous active-high reset
//   i_riscv_fetchctrl_pc, _is_c        : current PC and compressed flag
//   i_riscv_fetchctrl_imem_ready       : imem accepts a new fetch address
//   i_riscv_fetchctrl_hazard_stall     : hazard unit stall request
//   i_riscv_fetchctrl_br_*             : execute-stage branch/jump redirect
//   i_riscv_fetchctrl_trap_*           : trap / mret redirect
//   i_riscv_fetchctrl_wfi, _irq_pending: WFI retiring, interrupt pending
//   o_riscv_fetchctrl_nextpc, _stallpc : PC register load value and hold
//   o_riscv_fetchctrl_flush            : flush IF/ID and ID/EX
//   o_riscv_fetchctrl_state            : FSM state for debug
//   o_riscv_fetchctrl_pcreg            : PC register output; the core wires it
//                                        back to i_riscv_fetchctrl_pc
//
// state | meaning
// BOOT  | first cycle after reset, fetch RESET_VEC
// RUN   | normal sequential fetch / redirect handling
// HOLD  | redirect accepted while imem busy, waiting to issue latched target
// SLEEP | WFI retired, waiting for an interrupt
module riscv_fetchctrl
  import riscv_pkg::*;
#(
  parameter int               width     = 64,
  parameter logic [width-1:0] RESET_VEC = '0
) (
  input  logic             i_riscv_fetchctrl_clk,
  input  logic             i_riscv_fetchctrl_rst,
  input  logic [width-1:0] i_riscv_fetchctrl_pc,
  input  logic             i_riscv_fetchctrl_is_c,
  input  logic             i_riscv_fetchctrl_imem_ready,
  input  logic             i_riscv_fetchctrl_hazard_stall,
  input  logic             i_riscv_fetchctrl_br_redirect,
  input  logic [width-1:0] i_riscv_fetchctrl_br_target,
  input  logic             i_riscv_fetchctrl_trap_valid,
  input  logic [width-1:0] i_riscv_fetchctrl_trap_vec,
  input  logic             i_riscv_fetchctrl_wfi,
  input  logic             i_riscv_fetchctrl_irq_pending,
  output logic [width-1:0] o_riscv_fetchctrl_nextpc,
  output logic             o_riscv_fetchctrl_stallpc,
  output logic             o_riscv_fetchctrl_flush,
  output logic [1:0]       o_riscv_fetchctrl_state,
  output logic [width-1:0] o_riscv_fetchctrl_pcreg
);

  fetch_state_e     state, state_nx;
  logic [width-1:0] latch_q, latch_nx;
  logic [width-1:0] seq_pc, redirect_tgt;
  logic             redirect;

  always_comb begin
    seq_pc          = i_riscv_fetchctrl_pc +
                      (i_riscv_fetchctrl_is_c ? width'(2) : width'(4));
    redirect_tgt    = i_riscv_fetchctrl_trap_valid ? i_riscv_fetchctrl_trap_vec
                                                   : i_riscv_fetchctrl_br_target;
    redirect_tgt[0] = 1'b0;
    // Traps are honoured in every non-boot state; branches only while running.
    redirect = i_riscv_fetchctrl_trap_valid ||
               (state == RUN && i_riscv_fetchctrl_br_redirect);

    o_riscv_fetchctrl_nextpc  = seq_pc;
    o_riscv_fetchctrl_stallpc = 1'b0;
    o_riscv_fetchctrl_flush   = 1'b0;
    state_nx                  = state;
    latch_nx                  = latch_q;

    if (state == BOOT) begin
      o_riscv_fetchctrl_nextpc = RESET_VEC;
      state_nx                 = RUN;
    end else if (redirect) begin
      o_riscv_fetchctrl_nextpc = redirect_tgt;
      o_riscv_fetchctrl_flush  = 1'b1;
      if (i_riscv_fetchctrl_imem_ready) begin
        state_nx = RUN;
      end else begin
        o_riscv_fetchctrl_stallpc = 1'b1;
        latch_nx                  = redirect_tgt;
        state_nx                  = HOLD;
      end
    end else if (state == HOLD) begin
      o_riscv_fetchctrl_nextpc  = latch_q;
      o_riscv_fetchctrl_stallpc = !i_riscv_fetchctrl_imem_ready;
      if (i_riscv_fetchctrl_imem_ready) state_nx = RUN;
    end else if (state == RUN && i_riscv_fetchctrl_wfi && !i_riscv_fetchctrl_irq_pending) begin
      o_riscv_fetchctrl_stallpc = 1'b1;
      state_nx                  = SLEEP;
    end else if (state == SLEEP && !i_riscv_fetchctrl_irq_pending) begin
      o_riscv_fetchctrl_stallpc = 1'b1;
    end else begin
      // RUN sequential fetch, or SLEEP waking on an interrupt.
      o_riscv_fetchctrl_stallpc = i_riscv_fetchctrl_hazard_stall || !i_riscv_fetchctrl_imem_ready;
      state_nx                  = RUN;
    end
  end

  always_ff @(posedge i_riscv_fetchctrl_clk) begin
    if (i_riscv_fetchctrl_rst) begin
      state   <= BOOT;
      latch_q <= '0;
    end else begin
      state   <= state_nx;
      latch_q <= latch_nx;
    end
  end

  assign o_riscv_fetchctrl_state = state;

  riscv_pc #(
    .width    (width),
    .RESET_VEC(RESET_VEC)
  ) u_pc (
    .clk    (i_riscv_fetchctrl_clk),
    .rst    (i_riscv_fetchctrl_rst),
    .nextpc (o_riscv_fetchctrl_nextpc),
    .stallpc(o_riscv_fetchctrl_stallpc),
    .o_pc   (o_riscv_fetchctrl_pcreg)
  );

endmodule

// File: tb/tb_riscv_fetchctrl.sv
module tb_riscv_fetchctrl;

  localparam logic [63:0] RV = 64'h1000;
  localparam int M_BOOT = 0, M_RUN = 1, M_HOLD = 2, M_SLEEP = 3;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        force_en = 1'b0;
  logic [63:0] force_pc = '0;
  logic [63:0] pc_in;
  logic        is_c = 1'b0, ready = 1'b0, hazard = 1'b0;
  logic        br = 1'b0, trap = 1'b0, wfi = 1'b0, irq = 1'b0;
  logic [63:0] br_target = '0, trap_vec = '0;
  logic [63:0] nextpc, pcreg;
  logic        stallpc, flush;
  logic [1:0]  state;

  int checks = 0;
  int errors = 0;

  // reference model state
  int          m_state = M_BOOT;
  logic [63:0] m_latch = '0;
  logic [63:0] m_pcreg = RV;
  // model outputs for the current cycle
  logic [63:0] e_np, e_latch;
  logic        e_st, e_fl;
  int          e_state;

  always #5 clk = ~clk;

  // The PC register normally feeds back into the controller; tests may override it.
  assign pc_in = force_en ? force_pc : pcreg;

  riscv_fetchctrl #(.width(64), .RESET_VEC(RV)) dut (
    .i_riscv_fetchctrl_clk         (clk),
    .i_riscv_fetchctrl_rst         (rst),
    .i_riscv_fetchctrl_pc          (pc_in),
    .i_riscv_fetchctrl_is_c        (is_c),
    .i_riscv_fetchctrl_imem_ready  (ready),
    .i_riscv_fetchctrl_hazard_stall(hazard),
    .i_riscv_fetchctrl_br_redirect (br),
    .i_riscv_fetchctrl_br_target   (br_target),
    .i_riscv_fetchctrl_trap_valid  (trap),
    .i_riscv_fetchctrl_trap_vec    (trap_vec),
    .i_riscv_fetchctrl_wfi         (wfi),
    .i_riscv_fetchctrl_irq_pending (irq),
    .o_riscv_fetchctrl_nextpc      (nextpc),
    .o_riscv_fetchctrl_stallpc     (stallpc),
    .o_riscv_fetchctrl_flush       (flush),
    .o_riscv_fetchctrl_state       (state),
    .o_riscv_fetchctrl_pcreg       (pcreg)
  );

  // Behavioural model: decide what the fetch unit should do this cycle.
  task automatic model_eval();
    logic [63:0] cur_pc, tgt;
    logic        take;
    cur_pc  = force_en ? force_pc : m_pcreg;
    e_np    = cur_pc + (is_c ? 64'd2 : 64'd4);
    e_st    = 1'b0;
    e_fl    = 1'b0;
    e_state = m_state;
    e_latch = m_latch;
    tgt     = trap ? trap_vec : br_target;
    tgt     = {tgt[63:1], 1'b0};
    take    = trap || (br && m_state == M_RUN);
    if (m_state == M_BOOT) begin
      e_np = RV;
      e_state = M_RUN;
    end else if (take) begin
      e_np = tgt;
      e_fl = 1'b1;
      if (ready) e_state = M_RUN;
      else begin e_st = 1'b1; e_latch = tgt; e_state = M_HOLD; end
    end else if (m_state == M_HOLD) begin
      e_np = m_latch;
      e_st = !ready;
      if (ready) e_state = M_RUN;
    end else if (m_state == M_RUN && wfi && !irq) begin
      e_st = 1'b1;
      e_state = M_SLEEP;
    end else if (m_state == M_SLEEP && !irq) begin
      e_st = 1'b1;
    end else begin
      e_st = hazard || !ready;
      e_state = M_RUN;
    end
  endtask

  task automatic tick();
    model_eval();
    @(posedge clk);
    if (rst) begin
      m_state = M_BOOT; m_latch = '0; m_pcreg = RV;
    end else begin
      if (!e_st) m_pcreg = e_np;
      m_state = e_state;
      m_latch = e_latch;
    end
    @(negedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    force_en = 1'b0; is_c = 1'b0; ready = 1'b1; hazard = 1'b0;
    br = 1'b0; trap = 1'b0; wfi = 1'b0; irq = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    br = 1'b1; trap = 1'b1; wfi = 1'b1; br_target = 64'h1234; trap_vec = 64'h5678;
    tick(); tick();
    checks++; if (state !== 2'd0) begin errors++; $display("FAIL reset_state: got %0d expected 0", state); end
    checks++; if (nextpc !== RV) begin errors++; $display("FAIL reset_nextpc: got %h expected %h", nextpc, RV); end
    checks++; if (stallpc !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL reset_ctl: got stall=%b flush=%b expected 0/0", stallpc, flush); end
    idle_inputs();
  endtask

  task automatic test_boot_seq();
    idle_inputs();
    rst = 1'b0;
    #1;
    checks++; if (nextpc !== 64'h1000 || state !== 2'd0) begin errors++; $display("FAIL boot_first: got nextpc=%h state=%0d expected 1000/0", nextpc, state); end
    tick();
    checks++; if (nextpc !== 64'h1004 || stallpc !== 1'b0) begin errors++; $display("FAIL boot_seq4: got nextpc=%h stall=%b expected 1004/0", nextpc, stallpc); end
    tick();
    is_c = 1'b1; #1;
    checks++; if (nextpc !== 64'h1006) begin errors++; $display("FAIL boot_seq2: got %h expected 1006", nextpc); end
    tick();
  endtask

  task automatic test_priority();
    idle_inputs();
    br = 1'b1; br_target = 64'h2000; trap = 1'b1; trap_vec = 64'h8000; #1;
    checks++; if (nextpc !== 64'h8000 || flush !== 1'b1 || stallpc !== 1'b0) begin errors++; $display("FAIL prio_trap: got nextpc=%h flush=%b stall=%b expected 8000/1/0", nextpc, flush, stallpc); end
    tick();
    br = 1'b0; trap = 1'b0; #1;
    checks++; if (flush !== 1'b0 || pcreg !== 64'h8000 || nextpc !== 64'h8004) begin errors++; $display("FAIL prio_after: got flush=%b pc=%h nextpc=%h expected 0/8000/8004", flush, pcreg, nextpc); end
    hazard = 1'b1; br = 1'b1; br_target = 64'h2222; #1;
    checks++; if (stallpc !== 1'b0 || nextpc !== 64'h2222) begin errors++; $display("FAIL br_over_hazard: got stall=%b nextpc=%h expected 0/2222", stallpc, nextpc); end
    tick();
  endtask

  task automatic test_hold();
    idle_inputs();
    ready = 1'b0; br = 1'b1; br_target = 64'h3001; #1;
    checks++; if (stallpc !== 1'b1 || flush !== 1'b1) begin errors++; $display("FAIL hold_enter: got stall=%b flush=%b expected 1/1", stallpc, flush); end
    tick();
    br_target = 64'h5000;
    for (int i = 0; i < 2; i++) begin
      checks++; if (state !== 2'd2 || stallpc !== 1'b1 || flush !== 1'b0) begin errors++; $display("FAIL hold_wait: got state=%0d stall=%b flush=%b expected 2/1/0", state, stallpc, flush); end
      tick();
    end
    br = 1'b0; ready = 1'b1; #1;
    checks++; if (nextpc !== 64'h3000 || stallpc !== 1'b0 || flush !== 1'b0) begin errors++; $display("FAIL hold_release: got nextpc=%h stall=%b flush=%b expected 3000/0/0", nextpc, stallpc, flush); end
    tick();
    checks++; if (state !== 2'd1 || pcreg !== 64'h3000) begin errors++; $display("FAIL hold_back_run: got state=%0d pc=%h expected 1/3000", state, pcreg); end
    // trap arriving while already holding replaces the pending target
    ready = 1'b0; br = 1'b1; br_target = 64'h4000;
    tick();
    br = 1'b0; trap = 1'b1; trap_vec = 64'h9001; #1;
    checks++; if (flush !== 1'b1 || stallpc !== 1'b1) begin errors++; $display("FAIL hold_trap: got flush=%b stall=%b expected 1/1", flush, stallpc); end
    tick();
    trap = 1'b0; ready = 1'b1; #1;
    checks++; if (nextpc !== 64'h9000 || state !== 2'd2 || flush !== 1'b0) begin errors++; $display("FAIL hold_trap_release: got nextpc=%h state=%0d flush=%b expected 9000/2/0", nextpc, state, flush); end
    tick();
  endtask

  task automatic test_wrap();
    idle_inputs();
    force_en = 1'b1; force_pc = 64'hFFFF_FFFF_FFFF_FFFC; #1;
    checks++; if (nextpc !== 64'h0) begin errors++; $display("FAIL wrap4: got %h expected 0", nextpc); end
    is_c = 1'b1; force_pc = 64'hFFFF_FFFF_FFFF_FFFE; #1;
    checks++; if (nextpc !== 64'h0) begin errors++; $display("FAIL wrap2: got %h expected 0", nextpc); end
    tick();
    force_en = 1'b0; is_c = 1'b0;
    tick();
  endtask

  task automatic test_wfi();
    logic [63:0] p;
    idle_inputs();
    wfi = 1'b1; #1;
    checks++; if (stallpc !== 1'b1) begin errors++; $display("FAIL wfi_enter: got stall=%b expected 1", stallpc); end
    p = m_pcreg;
    tick();
    wfi = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++; if (stallpc !== 1'b1 || state !== 2'd3) begin errors++; $display("FAIL wfi_sleep: got stall=%b state=%0d expected 1/3", stallpc, state); end
      tick();
    end
    irq = 1'b1; #1;
    checks++; if (stallpc !== 1'b0 || nextpc !== p + 64'd4) begin errors++; $display("FAIL wfi_wake: got stall=%b nextpc=%h expected 0/%h", stallpc, nextpc, p + 64'd4); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wfi_run: got state=%0d expected 1", state); end
    wfi = 1'b1; irq = 1'b1; #1;
    checks++; if (stallpc !== 1'b0) begin errors++; $display("FAIL wfi_ignored: got stall=%b expected 0", stallpc); end
    tick();
    checks++; if (state !== 2'd1) begin errors++; $display("FAIL wfi_ignored_state: got state=%0d expected 1", state); end
  endtask

  task automatic test_rst_mid_hold();
    idle_inputs();
    ready = 1'b0; br = 1'b1; br_target = 64'h7000;
    tick();
    br = 1'b0;
    checks++; if (state !== 2'd2) begin errors++; $display("FAIL rsthold_pre: got state=%0d expected 2", state); end
    rst = 1'b1;
    tick();
    checks++; if (state !== 2'd0 || nextpc !== RV || dut.latch_q !== 64'h0) begin errors++; $display("FAIL rsthold_boot: got state=%0d nextpc=%h latch=%h expected 0/%h/0", state, nextpc, dut.latch_q, RV); end
    rst = 1'b0; ready = 1'b1;
    tick();
    checks++; if (state !== 2'd1 || pcreg !== RV) begin errors++; $display("FAIL rsthold_run: got state=%0d pc=%h expected 1/%h", state, pcreg, RV); end
  endtask

  task automatic test_random();
    for (int n = 0; n < 3000; n++) begin
      rst       = ($urandom_range(199) == 0);
      ready     = ($urandom_range(3) != 0);
      hazard    = ($urandom_range(4) == 0);
      br        = ($urandom_range(5) == 0);
      trap      = ($urandom_range(11) == 0);
      wfi       = ($urandom_range(7) == 0);
      irq       = ($urandom_range(2) == 0);
      is_c      = $urandom_range(1) == 1;
      br_target = {$urandom, $urandom};
      trap_vec  = {$urandom, $urandom};
      force_en  = ($urandom_range(9) == 0);
      force_pc  = {$urandom, $urandom};
      #1;
      model_eval();
      checks++;
      if ((!e_st && nextpc !== e_np) || stallpc !== e_st || flush !== e_fl ||
          state !== 2'(m_state) || pcreg !== m_pcreg) begin
        errors++;
        $display("FAIL random[%0d]: got np=%h st=%b fl=%b state=%0d pc=%h expected np=%h st=%b fl=%b state=%0d pc=%h",
                 n, nextpc, stallpc, flush, state, pcreg, e_np, e_st, e_fl, m_state, m_pcreg);
      end
      tick();
    end
    rst = 1'b0;
  endtask

  initial begin
    @(negedge clk); #1;
    test_reset();
    test_boot_seq();
    test_priority();
    test_hold();
    test_wrap();
    test_wfi();
    test_rst_mid_hold();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
